uart_tx_axis: RTL

//  UART transmitter. It accepts bytes on an AXI-Stream slave port and serialises them onto tx_wire.

---
 rtl/uart_tx_axis.sv | 115 +++++++++++
 1 files changed

// File: rtl/uart_tx_axis.sv
// UART transmitter that serialises AXI-Stream bytes as start, data (LSB first), optional parity and stop bits.
// tx_wire is registered from the FSM state, so the start bit appears one clock after the handshake edge.
module uart_tx_axis #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD_RATE  = 9600,
    parameter int DATA_WIDTH = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    output logic                  tx_wire,
    output logic                  tx_busy
);
    localparam int BIT_PERIOD = CLK_FREQ / BAUD_RATE;
    localparam int CW         = $clog2(BIT_PERIOD);
    localparam int BW         = $clog2(DATA_WIDTH) + 1;

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         baud_q, baud_d;
    logic [BW-1:0]         bit_q, bit_d;
    logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
    logic                  par_q, par_d;
    logic                  tx_q, tx_d;
    logic                  wrap;

    assign wrap = (baud_q == CW'(BIT_PERIOD - 1));

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        par_d   = par_q;
        tx_d    = 1'b1;
        if (state_q != IDLE) begin
            baud_d = wrap ? '0 : baud_q + CW'(1);
        end
        case (state_q)
            IDLE: begin
                if (s_axis_tvalid) begin
                    shreg_d = s_axis_tdata;
                    par_d   = (PARITY == 1) ? ~^s_axis_tdata : ^s_axis_tdata;
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = START;
                end
            end
            START: begin
                tx_d = 1'b0;
                if (wrap) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                tx_d = shreg_q[0];
                if (wrap) begin
                    shreg_d = shreg_q >> 1;
                    if (bit_q == BW'(DATA_WIDTH - 1)) begin
                        bit_d   = '0;
                        state_d = (PARITY != 0) ? PAR : STOP;
                    end else begin
                        bit_d = bit_q + BW'(1);
                    end
                end
            end
            PAR: begin
                tx_d = par_q;
                if (wrap) begin
                    state_d = STOP;
                end
            end
            STOP: begin
                // bit_q is reused to count stop bits
                if (wrap) begin
                    if (bit_q == BW'(STOP_BITS - 1)) begin
                        bit_d   = '0;
                        state_d = IDLE;
                    end else begin
                        bit_d = bit_q + BW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
        end
    end

    assign s_axis_tready = (state_q == IDLE) && !rst;
    assign tx_busy       = (state_q != IDLE);
    assign tx_wire       = tx_q;

endmodule
